// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: merges NUM_PORTS
// sources into one master, holding each grant from first beat to tlast.
//
// Ports:
//   s_aclk, s_aresetn        clock, async active-low reset
//   s_axis_t{data,keep,last,valid} / s_axis_tready
//                            packed per-port slave streams
//   m_axis_t{data,keep,last,dest,valid} / m_axis_tready
//                            merged master stream, tdest = source index
//   fifo_almost_full         blocks the start of new packets
//   grant_active, grant_idx  grant status / round-robin pointer
//   pkt_trunc                one-cycle pulse after a forced tlast

module axis_pkt_rr_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int TDATA_WIDTH   = 32,
    parameter int MAX_PKT_BEATS = 1024,
    localparam int IDX_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                 s_aclk,
    input  logic                                 s_aresetn,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    output logic [TDATA_WIDTH-1:0]               m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic [IDX_WIDTH-1:0]                 m_axis_tdest,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    input  logic                                 fifo_almost_full,
    output logic                                 grant_active,
    output logic [IDX_WIDTH-1:0]                 grant_idx,
    output logic                                 pkt_trunc
);

    localparam int KEEP_W  = TDATA_WIDTH / 8;
    localparam int CNT_W   = $clog2(MAX_PKT_BEATS) + 1;
    localparam int TRUNC_I = (MAX_PKT_BEATS > 0) ? MAX_PKT_BEATS - 1 : 0;

    localparam logic [CNT_W-1:0]     TRUNC_AT  = CNT_W'(TRUNC_I);
    localparam logic [IDX_WIDTH-1:0] LAST_PORT = IDX_WIDTH'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_WIDTH-1:0] grant_q;
    logic [IDX_WIDTH-1:0] grant_nxt;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     beat_cnt_nxt;
    logic                 trunc_q;
    logic                 trunc_nxt;

    logic [TDATA_WIDTH-1:0] src_data [NUM_PORTS];
    logic [KEEP_W-1:0]      src_keep [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign src_data[i] = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        assign src_keep[i] = s_axis_tkeep[i*KEEP_W +: KEEP_W];
    end

    // Round-robin pick: scan from the farthest candidate back toward
    // grant_q+1 so the nearest valid port after the pointer wins.
    logic [IDX_WIDTH-1:0] pick;
    logic                 req_any;

    always_comb begin
        int                   p;
        logic [IDX_WIDTH-1:0] pi;
        pick    = grant_q;
        req_any = |s_axis_tvalid;
        p       = 0;
        pi      = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            p  = (int'(grant_q) + k) % NUM_PORTS;
            pi = IDX_WIDTH'(p);
            if (s_axis_tvalid[pi]) begin
                pick = pi;
            end
        end
    end

    logic trunc_beat;
    logic cur_valid;
    logic cur_last;

    assign trunc_beat = (MAX_PKT_BEATS != 0) && (beat_cnt == TRUNC_AT);
    assign cur_valid  = s_axis_tvalid[grant_q];
    assign cur_last   = s_axis_tlast[grant_q];

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state    <= IDLE;
            grant_q  <= LAST_PORT;
            beat_cnt <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            trunc_q  <= trunc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        beat_cnt_nxt  = beat_cnt;
        trunc_nxt     = 1'b0;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_almost_full && req_any) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_axis_tvalid          = cur_valid;
                m_axis_tdata           = src_data[grant_q];
                m_axis_tkeep           = src_keep[grant_q];
                m_axis_tlast           = cur_last | trunc_beat;
                s_axis_tready[grant_q] = m_axis_tready;
                if (cur_valid && m_axis_tready) begin
                    if (cur_last || trunc_beat) begin
                        // grant_q is kept as the round-robin pointer
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                        trunc_nxt    = trunc_beat & ~cur_last;
                    end else if (MAX_PKT_BEATS != 0) begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_axis_tdest = grant_q;
    assign grant_idx    = grant_q;
    assign grant_active = (state == BUSY);
    assign pkt_trunc    = trunc_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomised and directed bench for axis_pkt_rr_arbiter with a
// packet-level reference model of the round-robin merge.

module tb_axis_pkt_rr_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int MAXB = 8;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [IW-1:0]     m_axis_tdest;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              fifo_almost_full;
    logic              grant_active;
    logic [IW-1:0]     grant_idx;
    logic              pkt_trunc;

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(
        .NUM_PORTS    (NP),
        .TDATA_WIDTH  (DW),
        .MAX_PKT_BEATS(MAXB)
    ) dut (
        .s_aclk          (clk),
        .s_aresetn       (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tdest    (m_axis_tdest),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .fifo_almost_full(fifo_almost_full),
        .grant_active    (grant_active),
        .grant_idx       (grant_idx),
        .pkt_trunc       (pkt_trunc)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t srcq [NP][$];

    int checks = 0;
    int errors = 0;
    int vprob  = 100;
    int rprob  = 100;
    bit af_knob = 1'b0;
    int seq = 0;
    int cyc = 0;
    int trunc_cnt = 0;

    // reference model state
    bit m_busy;
    int m_g;
    int m_cnt;
    bit m_trunc;
    bit acc [NP];

    int          log_dest[$];
    bit          log_last[$];
    int          log_cyc[$];
    logic [31:0] log_data[$];
    int          starts[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_g     = NP - 1;
        m_cnt   = 0;
        m_trunc = 1'b0;
        for (int i = 0; i < NP; i++) acc[i] = 1'b0;
    endtask

    task automatic clear_log();
        log_dest.delete();
        log_last.delete();
        log_cyc.delete();
        log_data.delete();
        trunc_cnt = 0;
    endtask

    task automatic push_pkt(int p, int len);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.d = {4'(p), 28'(seq)};
            x.k = 4'($urandom);
            x.l = (b == len - 1);
            srcq[p].push_back(x);
            seq++;
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NP; i++) n += srcq[i].size();
        return n;
    endfunction

    task automatic get_starts();
        starts.delete();
        foreach (log_dest[i])
            if (i == 0 || log_last[i-1]) starts.push_back(log_dest[i]);
    endtask

    // Sources keep tvalid asserted until the beat is taken.
    task automatic drive();
        bit hold;
        bit v;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) void'(srcq[i].pop_front());
            hold = s_axis_tvalid[i] && !acc[i];
            if (srcq[i].size() == 0) v = 1'b0;
            else if (hold) v = 1'b1;
            else v = ($urandom_range(99) < vprob);
            s_axis_tvalid[i] = v;
            if (srcq[i].size() > 0) begin
                s_axis_tdata[i*DW +: DW] = srcq[i][0].d;
                s_axis_tkeep[i*KW +: KW] = srcq[i][0].k;
                s_axis_tlast[i]          = srcq[i][0].l;
            end else begin
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tkeep[i*KW +: KW] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
            acc[i] = 1'b0;
        end
        m_axis_tready    = ($urandom_range(99) < rprob);
        fifo_almost_full = af_knob;
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tready"}, s_axis_tready, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_tdest"}, m_axis_tdest, NP - 1);
        chk({tag, "_grant_idx"}, grant_idx, NP - 1);
        chk({tag, "_grant_active"}, grant_active, 0);
        chk({tag, "_pkt_trunc"}, pkt_trunc, 0);
    endtask

    task automatic check();
        logic [NP-1:0] exp_rdy;
        logic [1:0]    gi;
        bit            ev;
        bit            el;
        if (!rst_n) begin
            check_reset_vals("rst");
            return;
        end
        gi = 2'(m_g);
        ev = m_busy && s_axis_tvalid[gi];
        el = m_busy && (s_axis_tlast[gi] || m_cnt == MAXB - 1);
        exp_rdy = '0;
        if (m_busy) exp_rdy[gi] = m_axis_tready;
        chk("tvalid", m_axis_tvalid, ev);
        chk("tready", s_axis_tready, exp_rdy);
        chk("grant_active", grant_active, m_busy);
        chk("grant_idx", grant_idx, gi);
        chk("tdest", m_axis_tdest, gi);
        chk("pkt_trunc", pkt_trunc, m_trunc);
        if (!m_busy) chk("tlast_idle", m_axis_tlast, 0);
        if (ev) begin
            chk("tlast", m_axis_tlast, el);
            chk("tdata", m_axis_tdata, srcq[gi][0].d);
            chk("tkeep", m_axis_tkeep, srcq[gi][0].k);
        end
        if (pkt_trunc === 1'b1) trunc_cnt++;
        m_trunc = 1'b0;
        if (!m_busy) begin
            if (!fifo_almost_full && (|s_axis_tvalid)) begin
                for (int k = 1; k <= NP; k++) begin
                    if (s_axis_tvalid[2'((m_g + k) % NP)]) begin
                        m_g = (m_g + k) % NP;
                        break;
                    end
                end
                m_busy = 1'b1;
            end
        end else if (ev && m_axis_tready) begin
            acc[gi] = 1'b1;
            log_dest.push_back(m_g);
            log_last.push_back(el);
            log_cyc.push_back(cyc);
            log_data.push_back(srcq[gi][0].d);
            if (el) begin
                if (!s_axis_tlast[gi]) m_trunc = 1'b1;
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        #3;
        check();
    endtask

    task automatic run_until_empty(int budget);
        int n = 0;
        while ((pending() > 0 || m_busy) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", pending(), 0);
        repeat (3) cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int total;
        int e3[3];
        s_axis_tdata     = '0;
        s_axis_tkeep     = '0;
        s_axis_tlast     = '0;
        s_axis_tvalid    = '0;
        m_axis_tready    = 1'b0;
        fifo_almost_full = 1'b0;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // idle with nothing requesting
        repeat (100) cycle();
        chk("idle_beats", log_dest.size(), 0);

        // four simultaneous 4-beat packets
        clear_log();
        seq = 0;
        for (int p = 0; p < NP; p++) push_pkt(p, 4);
        run_until_empty(200);
        get_starts();
        chk("t2_beats", log_dest.size(), 16);
        chk("t2_npkts", starts.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_order", starts.size() > i ? starts[i] : -1, i);
        if (log_cyc.size() == 16)
            chk("t2_span", log_cyc[15] - log_cyc[0], 18);
        else
            chk("t2_span_beats", log_cyc.size(), 16);
        chk("t2_data0", log_data.size() > 0 ? log_data[0] : 0,
            32'h0000_0000);
        chk("t2_data4", log_data.size() > 4 ? log_data[4] : 0,
            32'h1000_0004);

        // round-robin fairness after a port-2 packet
        clear_log();
        push_pkt(2, 3);
        push_pkt(2, 2);
        push_pkt(3, 2);
        run_until_empty(200);
        get_starts();
        e3 = '{2, 3, 2};
        chk("t3_beats", log_dest.size(), 7);
        chk("t3_npkts", starts.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t3_order", starts.size() > i ? starts[i] : -1, e3[i]);

        // almost_full blocks new grants only
        clear_log();
        af_knob = 1'b1;
        push_pkt(1, 6);
        repeat (10) cycle();
        chk("t4_no_grant", grant_active, 0);
        chk("t4_no_beats", log_dest.size(), 0);
        af_knob = 1'b0;
        cycle();
        cycle();
        chk("t4_grant", grant_active, 1);
        chk("t4_grant_idx", grant_idx, 1);
        n = 0;
        while (log_dest.size() < 2 && n < 50) begin
            cycle();
            n++;
        end
        af_knob = 1'b1;
        run_until_empty(100);
        af_knob = 1'b0;
        get_starts();
        chk("t4_beats", log_dest.size(), 6);
        chk("t4_npkts", starts.size(), 1);

        // truncation at 8 beats
        clear_log();
        push_pkt(0, 10);
        run_until_empty(100);
        get_starts();
        chk("t5_beats", log_dest.size(), 10);
        if (log_last.size() == 10) begin
            chk("t5_last8", log_last[7], 1);
            chk("t5_last9", log_last[8], 0);
            chk("t5_last10", log_last[9], 1);
        end
        chk("t5_npkts", starts.size(), 2);
        chk("t5_dest2", starts.size() > 1 ? starts[1] : -1, 0);
        chk("t5_trunc_pulses", trunc_cnt, 1);

        // random traffic, gaps and backpressure
        clear_log();
        vprob = 70;
        rprob = 50;
        total = 0;
        for (int i = 0; i < 1000; i++) begin
            n = $urandom_range(1, 12);
            push_pkt($urandom_range(NP - 1), n);
            total += n;
        end
        run_until_empty(60000);
        chk("t6_beats", log_dest.size(), total);

        // async reset on beat 2 of 5
        vprob = 100;
        rprob = 100;
        clear_log();
        push_pkt(0, 5);
        n = 0;
        while (!(m_busy && m_cnt == 1) && n < 50) begin
            cycle();
            n++;
        end
        chk("t7_reached_beat2", m_cnt, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_tready", s_axis_tready, 0);
        chk("t7_tvalid", m_axis_tvalid, 0);
        chk("t7_active", grant_active, 0);
        chk("t7_grant_idx", grant_idx, NP - 1);
        model_reset();
        for (int i = 0; i < NP; i++) srcq[i].delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        clear_log();
        push_pkt(3, 2);
        push_pkt(0, 2);
        run_until_empty(100);
        get_starts();
        chk("t7_first", starts.size() > 0 ? starts[0] : -1, 0);
        chk("t7_second", starts.size() > 1 ? starts[1] : -1, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
